// File: rtl/data_mem_arbiter.sv
// Two-port round-robin arbiter and access sequencer for a single-port data memory.
// Optional feature macro DMEM_ARB_STATS_EN adds per-port saturating grant counters.
module data_mem_arbiter #(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ack,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ack,
  output logic [DATA_W-1:0] p1_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_write_en,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic              busy
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0]       p0_grant_cnt,
  output logic [15:0]       p1_grant_cnt
`endif
);

  localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_grant_q, last_grant_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              p0_ack_q, p0_ack_d;
  logic              p1_ack_q, p1_ack_d;
  logic [DATA_W-1:0] p0_rdata_q, p0_rdata_d;
  logic [DATA_W-1:0] p1_rdata_q, p1_rdata_d;
  logic [ADDR_W-1:0] mem_address_q, mem_address_d;
  logic              mem_write_en_q, mem_write_en_d;
  logic [DATA_W-1:0] mem_write_data_q, mem_write_data_d;
  logic              busy_q, busy_d;

  // Next state plus next values of every registered output, so outputs line up with the state.
  always_comb begin
    state_d          = state_q;
    owner_d          = owner_q;
    last_grant_d     = last_grant_q;
    we_d             = we_q;
    addr_d           = addr_q;
    wdata_d          = wdata_q;
    wait_cnt_d       = wait_cnt_q;
    rdata_d          = rdata_q;
    p0_ack_d         = 1'b0;
    p1_ack_d         = 1'b0;
    p0_rdata_d       = '0;
    p1_rdata_d       = '0;
    mem_address_d    = '0;
    mem_write_en_d   = 1'b0;
    mem_write_data_d = '0;

    unique case (state_q)
      IDLE: begin
        if (p0_req || p1_req) begin
          // Tie goes to the port that did not win last time.
          owner_d          = (p0_req && p1_req) ? ~last_grant_q : p1_req;
          we_d             = owner_d ? p1_we    : p0_we;
          addr_d           = owner_d ? p1_addr  : p0_addr;
          wdata_d          = owner_d ? p1_wdata : p0_wdata;
          wait_cnt_d       = CNT_LOAD;
          state_d          = ACCESS;
          mem_address_d    = addr_d;
          mem_write_data_d = wdata_d;
          mem_write_en_d   = we_d && (wait_cnt_d == '0);
        end
      end
      ACCESS: begin
        if (wait_cnt_q == '0) begin
          state_d = DONE;
          if (!we_q) begin
            rdata_d = mem_read_data;
          end
          p0_ack_d   = ~owner_q;
          p1_ack_d   = owner_q;
          p0_rdata_d = owner_q ? '0 : rdata_d;
          p1_rdata_d = owner_q ? rdata_d : '0;
        end else begin
          wait_cnt_d       = wait_cnt_q - CNT_W'(1);
          mem_address_d    = addr_q;
          mem_write_data_d = wdata_q;
          mem_write_en_d   = we_q && (wait_cnt_d == '0);
        end
      end
      DONE: begin
        last_grant_d = owner_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= IDLE;
      owner_q          <= 1'b0;
      last_grant_q     <= 1'b1;
      we_q             <= 1'b0;
      addr_q           <= '0;
      wdata_q          <= '0;
      wait_cnt_q       <= '0;
      rdata_q          <= '0;
      p0_ack_q         <= 1'b0;
      p1_ack_q         <= 1'b0;
      p0_rdata_q       <= '0;
      p1_rdata_q       <= '0;
      mem_address_q    <= '0;
      mem_write_en_q   <= 1'b0;
      mem_write_data_q <= '0;
      busy_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      owner_q          <= owner_d;
      last_grant_q     <= last_grant_d;
      we_q             <= we_d;
      addr_q           <= addr_d;
      wdata_q          <= wdata_d;
      wait_cnt_q       <= wait_cnt_d;
      rdata_q          <= rdata_d;
      p0_ack_q         <= p0_ack_d;
      p1_ack_q         <= p1_ack_d;
      p0_rdata_q       <= p0_rdata_d;
      p1_rdata_q       <= p1_rdata_d;
      mem_address_q    <= mem_address_d;
      mem_write_en_q   <= mem_write_en_d;
      mem_write_data_q <= mem_write_data_d;
      busy_q           <= busy_d;
    end
  end

  assign p0_ack         = p0_ack_q;
  assign p1_ack         = p1_ack_q;
  assign p0_rdata       = p0_rdata_q;
  assign p1_rdata       = p1_rdata_q;
  assign mem_address    = mem_address_q;
  assign mem_write_en   = mem_write_en_q;
  assign mem_write_data = mem_write_data_q;
  assign busy           = busy_q;

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] p0_grant_cnt_q, p0_grant_cnt_d;
  logic [15:0] p1_grant_cnt_q, p1_grant_cnt_d;

  // Count completed transactions in the owner's DONE cycle, saturating.
  always_comb begin
    p0_grant_cnt_d = p0_grant_cnt_q;
    p1_grant_cnt_d = p1_grant_cnt_q;
    if (state_q == DONE) begin
      if (!owner_q && (p0_grant_cnt_q != 16'hFFFF)) begin
        p0_grant_cnt_d = p0_grant_cnt_q + 16'd1;
      end
      if (owner_q && (p1_grant_cnt_q != 16'hFFFF)) begin
        p1_grant_cnt_d = p1_grant_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p0_grant_cnt_q <= '0;
      p1_grant_cnt_q <= '0;
    end else begin
      p0_grant_cnt_q <= p0_grant_cnt_d;
      p1_grant_cnt_q <= p1_grant_cnt_d;
    end
  end

  assign p0_grant_cnt = p0_grant_cnt_q;
  assign p1_grant_cnt = p1_grant_cnt_q;
`endif

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: two instances (WAIT_CYCLES 1 and 3), each with its own memory,
// a transaction-schedule reference model, directed scenarios and randomized masters.
`timescale 1ns/1ps
module tb_data_mem_arbiter;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  task automatic chk(input int inst, input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL inst%0d %s: got %0h expected %0h at %0t", inst, nm, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int W = (g == 0) ? 1 : 3;

    logic          reset = 1'b0;
    logic [1:0]    req = '0;
    logic [1:0]    we  = '0;
    logic [AW-1:0] addr  [2];
    logic [DW-1:0] wdata [2];
    logic [1:0]    ack;
    logic [DW-1:0] rdata [2];
    logic [AW-1:0] mem_address;
    logic          mem_write_en;
    logic [DW-1:0] mem_write_data;
    logic [DW-1:0] mem_read_data;
    logic          busy;
    bit            done = 1'b0;
`ifdef DMEM_ARB_STATS_EN
    logic [15:0]   cnt0, cnt1;
`endif

    data_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(W)) u_dut (
      .clk(clk), .reset(reset),
      .p0_req(req[0]), .p0_we(we[0]), .p0_addr(addr[0]), .p0_wdata(wdata[0]),
      .p0_ack(ack[0]), .p0_rdata(rdata[0]),
      .p1_req(req[1]), .p1_we(we[1]), .p1_addr(addr[1]), .p1_wdata(wdata[1]),
      .p1_ack(ack[1]), .p1_rdata(rdata[1]),
      .mem_address(mem_address), .mem_write_en(mem_write_en),
      .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
      .busy(busy)
`ifdef DMEM_ARB_STATS_EN
      , .p0_grant_cnt(cnt0), .p1_grant_cnt(cnt1)
`endif
    );

    // DataMemory stand-in: combinational read, write on the clock edge.
    logic [DW-1:0] mem     [0:65535];
    logic [DW-1:0] ref_mem [0:65535];
    int wr_edges  = 0;
    int ack_seen  = 0;
    initial for (int i = 0; i < 65536; i++) begin mem[i] = '0; ref_mem[i] = '0; end
    assign mem_read_data = mem[mem_address];
    always @(posedge clk) begin
      if (mem_write_en) begin mem[mem_address] <= mem_write_data; wr_edges++; end
    end
    always @(negedge clk) if (ack != 2'b00) ack_seen++;

    // Reference model: t = phase of the coming cycle (0 idle, 1..W access, W+1 done).
    int            t = 0;
    logic          own = 1'b0, lg = 1'b1, lwe = 1'b0;
    logic [AW-1:0] la = '0;
    logic [DW-1:0] lwd = '0, rd_q = '0;
    int            e_cnt [2] = '{0, 0};
    logic          e_busy = 1'b0, e_we = 1'b0;
    logic [1:0]    e_ack = '0;
    logic [AW-1:0] e_addr = '0;
    logic [DW-1:0] e_wd = '0, e_rd0 = '0, e_rd1 = '0;

    always @(posedge clk or posedge reset) begin
      if (reset) begin
        t = 0; lg = 1'b1; rd_q = '0; e_cnt[0] = 0; e_cnt[1] = 0;
      end else if (t == 0) begin
        if (req != 2'b00) begin
          own = (req == 2'b11) ? !lg : req[1];
          lwe = we[own]; la = addr[own]; lwd = wdata[own];
          t = 1;
        end
      end else if (t <= W) begin
        if (t == W) begin
          if (lwe) ref_mem[la] = lwd;
          else     rd_q = ref_mem[la];
        end
        t++;
      end else begin
        lg = own;
        if (e_cnt[own] < 65535) e_cnt[own]++;
        t = 0;
      end
      e_busy = (t != 0);
      e_addr = (t >= 1 && t <= W) ? la  : '0;
      e_wd   = (t >= 1 && t <= W) ? lwd : '0;
      e_we   = (t == W) && lwe;
      e_ack  = (t == W + 1) ? (own ? 2'b10 : 2'b01) : 2'b00;
      e_rd0  = e_ack[0] ? rd_q : '0;
      e_rd1  = e_ack[1] ? rd_q : '0;
    end

    always @(negedge clk) begin
      chk(g, "busy",           64'(busy),           64'(e_busy));
      chk(g, "mem_address",    64'(mem_address),    64'(e_addr));
      chk(g, "mem_write_en",   64'(mem_write_en),   64'(e_we));
      chk(g, "mem_write_data", 64'(mem_write_data), 64'(e_wd));
      chk(g, "acks",           64'(ack),            64'(e_ack));
      chk(g, "p0_rdata",       64'(rdata[0]),       64'(e_rd0));
      chk(g, "p1_rdata",       64'(rdata[1]),       64'(e_rd1));
`ifdef DMEM_ARB_STATS_EN
      chk(g, "p0_grant_cnt",   64'(cnt0),           64'(e_cnt[0]));
      chk(g, "p1_grant_cnt",   64'(cnt1),           64'(e_cnt[1]));
`endif
    end

    // One transaction from idle; returns rdata at ack and negedges from request to ack.
    task automatic do_xfer(input int p, input logic w, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, output logic [DW-1:0] rd, output int lat);
      req[p] = 1'b1; we[p] = w; addr[p] = a; wdata[p] = d; lat = 0; rd = '0;
      do begin @(negedge clk); lat++; end while (!ack[p] && lat < 50);
      rd = rdata[p];
      req[p] = 1'b0;
      chk(g, "xfer_latency", 64'(lat), 64'(W + 1));
      @(negedge clk);
    endtask

    task automatic pulse_reset();
      @(negedge clk); req = '0; reset = 1'b1;
      @(negedge clk); reset = 1'b0;
      @(negedge clk);
    endtask

    task automatic master(input int p, input int ncyc);
      bit waiting = 1'b0;
      for (int c = 0; c < ncyc; c++) begin
        @(negedge clk);
        if (waiting && ack[p]) waiting = 1'b0;
        if (!waiting) begin
          if ($urandom_range(2, 0) != 0) begin
            req[p] = 1'b1; we[p] = 1'($urandom_range(1, 0));
            addr[p] = AW'($urandom_range(15, 0)); wdata[p] = $urandom; waiting = 1'b1;
          end else begin
            req[p] = 1'b0;
          end
        end else if ($urandom_range(15, 0) == 0) begin
          addr[p] = AW'($urandom_range(15, 0)); wdata[p] = $urandom;
        end
      end
      req[p] = 1'b0;
    endtask

    initial begin
      logic [DW-1:0] rd;
      int lat, n, coinc, wr0, a0;
      int owners [4];
      addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;
      #1 reset = 1'b1;
      repeat (2) @(negedge clk);
      chk(g, "rst_busy", 64'(busy), 64'd0);
      chk(g, "rst_acks", 64'(ack), 64'd0);
      chk(g, "rst_mem_address", 64'(mem_address), 64'd0);
      chk(g, "rst_mem_write_en", 64'(mem_write_en), 64'd0);
      reset = 1'b0;
      @(negedge clk);

      // Single write then read-back through port 0.
      wr0 = wr_edges;
      do_xfer(0, 1'b1, 16'd3, 32'h5, rd, lat);
      chk(g, "t2_write_edges", 64'(wr_edges - wr0), 64'd1);
      chk(g, "t2_mem3", 64'(mem[3]), 64'h5);
      do_xfer(0, 1'b0, 16'd3, 32'h0, rd, lat);
      chk(g, "t2_read3", 64'(rd), 64'h5);

      // Both ports requesting continuously from reset release alternate p0,p1,p0,p1.
      @(negedge clk); reset = 1'b1; req = 2'b11; we = 2'b00; addr[0] = 16'd3; addr[1] = 16'd4;
      @(negedge clk); reset = 1'b0;
      n = 0; coinc = 0;
      for (int c = 0; c < 60 && n < 4; c++) begin
        @(negedge clk);
        if (ack == 2'b11) coinc++;
        if (ack != 2'b00) begin owners[n] = ack[1] ? 1 : 0; n++; end
        if (n == 4) req = 2'b00;
      end
      req = 2'b00;
      chk(g, "t3_grant_count", 64'(n), 64'd4);
      chk(g, "t3_coincident_acks", 64'(coinc), 64'd0);
      for (int k = 0; k < 4; k++) chk(g, "t3_owner", 64'(owners[k]), 64'(k % 2));
      @(negedge clk);

      // Read-modify-write loop through port 1.
      for (int i = 0; i < 10; i++) begin
        do_xfer(1, 1'b1, AW'(i), DW'(i), rd, lat);
        do_xfer(1, 1'b0, AW'(i), '0, rd, lat);
        chk(g, "t4_read_i", 64'(rd), 64'(i));
        do_xfer(1, 1'b1, AW'(i), rd + 32'd5, rd, lat);
        do_xfer(1, 1'b0, AW'(i), '0, rd, lat);
        chk(g, "t4_read_i_plus5", 64'(rd), 64'(i + 5));
      end

      // Reset in the first access cycle of a write discards it.
      do_xfer(0, 1'b1, 16'd7, 32'hDEAD0007, rd, lat);
      wr0 = wr_edges; a0 = ack_seen;
      req[0] = 1'b1; we[0] = 1'b1; addr[0] = 16'd7; wdata[0] = 32'hBAD0BAD0;
      @(negedge clk);
      req[0] = 1'b0;
      chk(g, "t5_busy_before", 64'(busy), 64'd1);
      #2 reset = 1'b1;
      #1;
      chk(g, "t5_busy", 64'(busy), 64'd0);
      chk(g, "t5_write_en", 64'(mem_write_en), 64'd0);
      chk(g, "t5_mem_address", 64'(mem_address), 64'd0);
      chk(g, "t5_acks", 64'(ack), 64'd0);
      chk(g, "t5_p0_rdata", 64'(rdata[0]), 64'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (W + 2) @(negedge clk);
      chk(g, "t5_write_edges", 64'(wr_edges - wr0), 64'd0);
      chk(g, "t5_ack_count", 64'(ack_seen - a0), 64'd0);
      do_xfer(0, 1'b0, 16'd7, '0, rd, lat);
      chk(g, "t5_read7", 64'(rd), 64'hDEAD0007);

`ifdef DMEM_ARB_STATS_EN
      pulse_reset();
      for (int i = 0; i < 4; i++) do_xfer(0, 1'b1, AW'(40 + i), DW'(i), rd, lat);
      for (int i = 0; i < 2; i++) do_xfer(1, 1'b0, AW'(40 + i), '0, rd, lat);
      chk(g, "t6_p0_grant_cnt", 64'(cnt0), 64'd4);
      chk(g, "t6_p1_grant_cnt", 64'(cnt1), 64'd2);
`endif

      pulse_reset();
      fork
        master(0, 600);
        master(1, 600);
      join
      req = 2'b00;
      repeat (W + 4) @(negedge clk);
      done = 1'b1;
    end
  end

  initial begin
    for (int c = 0; c < 50000 && !(g_inst[0].done && g_inst[1].done); c++) @(negedge clk);
    chk(0, "all_done", 64'({g_inst[0].done, g_inst[1].done}), 64'(2'b11));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
